// File: rtl/dcpu16_memsys.sv
// Dual-port word memory for the DCPU-16 with per-port wait-state FSMs (IDLE/BUSY/ACK).
// Optional collision flag when DCPU16_MEMSYS_COLL_EN is defined.

module dcpu16_memsys_port #(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dto_i,
  input  logic          stb_i,
  input  logic          wre_i,
  input  logic [DW-1:0] rdat_i,
  output logic          acc_o,
  output logic          acc_we_o,
  output logic [AW-1:0] acc_adr_o,
  output logic [DW-1:0] acc_dat_o,
  output logic [DW-1:0] dti_o,
  output logic          ack_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          we_q, we_d;
  logic [DW-1:0] dti_q, dti_d;
  logic          busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      dti_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      dti_q   <= dti_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    dti_d   = dti_q;
    case (state_q)
      BUSY: begin
        if (!stb_i) state_d = IDLE;
        else begin
          cnt_d = cnt_q - 4'd1;
          if (acc_o) state_d = ACK;
        end
      end
      default: begin
        if (stb_i) begin
          adr_d = adr_i;
          dat_d = dto_i;
          we_d  = wre_i;
          cnt_d = 4'(WAIT);
          if (WAIT == 0) state_d = ACK;
          else           state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (acc_o && !acc_we_o) dti_d = rdat_i;
  end

  // A zero-wait access happens on the latch edge, so it uses the live inputs.
  always_comb begin
    busy      = (state_q == BUSY);
    acc_o     = stb_i && (busy ? (cnt_q == 4'd1) : (WAIT == 0));
    acc_adr_o = busy ? adr_q : adr_i;
    acc_dat_o = busy ? dat_q : dto_i;
    acc_we_o  = busy ? we_q  : wre_i;
    ack_o     = (state_q == ACK);
    dti_o     = dti_q;
  end
endmodule

module dcpu16_memsys #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int FWAIT = 0,
  parameter int GWAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   f_adr,
  input  logic [DW-1:0] f_dto,
  input  logic          f_stb,
  input  logic          f_wre,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  input  logic [15:0]   g_adr,
  input  logic [DW-1:0] g_dto,
  input  logic          g_stb,
  input  logic          g_wre,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  output logic          coll
);
  logic [DW-1:0] bram [2**AW];

  logic          f_acc, f_we, g_acc, g_we;
  logic [AW-1:0] f_a, g_a;
  logic [DW-1:0] f_d, g_d, f_rd, g_rd;
  logic          unused_adr_hi;

  assign unused_adr_hi = ^{f_adr, g_adr};

  dcpu16_memsys_port #(.AW(AW), .DW(DW), .WAIT(FWAIT)) u_f (
    .clk(clk), .rst(rst), .adr_i(f_adr[AW-1:0]), .dto_i(f_dto), .stb_i(f_stb),
    .wre_i(f_wre), .rdat_i(f_rd), .acc_o(f_acc), .acc_we_o(f_we), .acc_adr_o(f_a),
    .acc_dat_o(f_d), .dti_o(f_dti), .ack_o(f_ack)
  );

  dcpu16_memsys_port #(.AW(AW), .DW(DW), .WAIT(GWAIT)) u_g (
    .clk(clk), .rst(rst), .adr_i(g_adr[AW-1:0]), .dto_i(g_dto), .stb_i(g_stb),
    .wre_i(g_wre), .rdat_i(g_rd), .acc_o(g_acc), .acc_we_o(g_we), .acc_adr_o(g_a),
    .acc_dat_o(g_d), .dti_o(g_dti), .ack_o(g_ack)
  );

  assign f_rd = bram[f_a];
  assign g_rd = bram[g_a];

  // Port f is written last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (!rst && g_acc && g_we) bram[g_a] <= g_d;
    if (!rst && f_acc && f_we) bram[f_a] <= f_d;
  end

`ifdef DCPU16_MEMSYS_COLL_EN
  logic coll_q, coll_d;
  assign coll_d = f_acc && g_acc && (f_a == g_a) && (f_we || g_we);
  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll_d;
  end
  assign coll = coll_q;
`else
  assign coll = 1'b0;
`endif
endmodule

// File: tb/tb_dcpu16_memsys.sv
// Directed bench for dcpu16_memsys: dut0 (FWAIT=0, GWAIT=3) and dut1 (FWAIT=2, GWAIT=0).
module tb_dcpu16_memsys;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DCPU16_MEMSYS_COLL_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic        rst0, rst1;
  logic [15:0] f_adr, f_dto, g_adr, g_dto, f_dti, g_dti;
  logic        f_stb, f_wre, g_stb, g_wre, f_ack, g_ack, coll;
  logic [15:0] bf_adr, bf_dto, bg_adr, bg_dto, bf_dti, bg_dti;
  logic        bf_stb, bf_wre, bg_stb, bg_wre, bf_ack, bg_ack, bcoll;

  dcpu16_memsys #(.AW(16), .DW(16), .FWAIT(0), .GWAIT(3)) dut0 (
    .clk(clk), .rst(rst0),
    .f_adr(f_adr), .f_dto(f_dto), .f_stb(f_stb), .f_wre(f_wre), .f_dti(f_dti), .f_ack(f_ack),
    .g_adr(g_adr), .g_dto(g_dto), .g_stb(g_stb), .g_wre(g_wre), .g_dti(g_dti), .g_ack(g_ack),
    .coll(coll)
  );

  dcpu16_memsys #(.AW(16), .DW(16), .FWAIT(2), .GWAIT(0)) dut1 (
    .clk(clk), .rst(rst1),
    .f_adr(bf_adr), .f_dto(bf_dto), .f_stb(bf_stb), .f_wre(bf_wre), .f_dti(bf_dti), .f_ack(bf_ack),
    .g_adr(bg_adr), .g_dto(bg_dto), .g_stb(bg_stb), .g_wre(bg_wre), .g_dti(bg_dti), .g_ack(bg_ack),
    .coll(bcoll)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fwr(input logic [15:0] a, input logic [15:0] d);
    f_adr = a; f_dto = d; f_wre = 1'b1; f_stb = 1'b1;
    tick();
    chk("fwr_ack", f_ack, 1);
    f_stb = 1'b0; f_wre = 1'b0;
    tick();
  endtask

  task automatic frd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    f_adr = a; f_wre = 1'b0; f_stb = 1'b1;
    tick();
    chk({tag, "_ack"}, f_ack, 1);
    chk({tag, "_dti"}, f_dti, exp);
    f_stb = 1'b0;
    tick();
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    f_adr = '0; f_dto = '0; f_stb = 1'b0; f_wre = 1'b0;
    g_adr = '0; g_dto = '0; g_stb = 1'b0; g_wre = 1'b0;
    bf_adr = '0; bf_dto = '0; bf_stb = 1'b0; bf_wre = 1'b0;
    bg_adr = '0; bg_dto = '0; bg_stb = 1'b0; bg_wre = 1'b0;
    tick(); tick();
    chk("rst_f_ack", f_ack, 0);
    chk("rst_g_ack", g_ack, 0);
    chk("rst_f_dti", f_dti, 0);
    chk("rst_g_dti", g_dti, 0);
    chk("rst_coll", coll, 0);
    rst0 = 1'b0;
    tick();

    // Preload and zero-wait read; write leaves dti untouched.
    f_adr = 16'h0010; f_dto = 16'h1234; f_wre = 1'b1; f_stb = 1'b1;
    tick();
    chk("pre_ack", f_ack, 1);
    chk("pre_dti_unch", f_dti, 16'h0000);
    f_stb = 1'b0;
    tick();
    chk("pre_ack_drop", f_ack, 0);
    frd("rd10", 16'h0010, 16'h1234);
    chk("dti_hold", f_dti, 16'h1234);
    chk("ack_idle", f_ack, 0);

    // g write with 3 waits; wre dropped mid-BUSY must be ignored.
    g_adr = 16'h0020; g_dto = 16'hBEEF; g_wre = 1'b1; g_stb = 1'b1;
    tick(); chk("g_lat0", g_ack, 0);
    g_wre = 1'b0;
    tick(); chk("g_lat1", g_ack, 0);
    tick(); chk("g_lat2", g_ack, 0);
    tick(); chk("g_lat3", g_ack, 1);
    chk("g_wr_dti_unch", g_dti, 16'h0000);
    g_stb = 1'b0;
    tick(); chk("g_ack_1cyc", g_ack, 0);
    frd("rd20", 16'h0020, 16'hBEEF);

    // Aborted g write.
    fwr(16'h0030, 16'h0303);
    g_adr = 16'h0030; g_dto = 16'h5555; g_wre = 1'b1; g_stb = 1'b1;
    tick(); chk("abt0", g_ack, 0);
    tick(); chk("abt1", g_ack, 0);
    g_stb = 1'b0;
    tick(); chk("abt2", g_ack, 0);
    tick(); chk("abt3", g_ack, 0);
    tick(); chk("abt4", g_ack, 0);
    frd("rd30", 16'h0030, 16'h0303);

    // Same-address double write at the same edge: f wins.
    g_adr = 16'h0040; g_dto = 16'h5555; g_wre = 1'b1; g_stb = 1'b1;
    tick(); tick(); tick();
    f_adr = 16'h0040; f_dto = 16'hAAAA; f_wre = 1'b1; f_stb = 1'b1;
    tick();
    chk("ww_f_ack", f_ack, 1);
    chk("ww_g_ack", g_ack, 1);
    chk("ww_coll", coll, CE);
    f_stb = 1'b0; g_stb = 1'b0;
    tick();
    chk("ww_coll_drop", coll, 0);
    frd("rd40", 16'h0040, 16'hAAAA);

    // Same-address read (g) vs write (f): read sees old data.
    g_adr = 16'h0040; g_wre = 1'b0; g_stb = 1'b1;
    tick(); tick(); tick();
    f_adr = 16'h0040; f_dto = 16'h1357; f_wre = 1'b1; f_stb = 1'b1;
    tick();
    chk("rw_g_ack", g_ack, 1);
    chk("rw_g_old", g_dti, 16'hAAAA);
    chk("rw_coll", coll, CE);
    f_stb = 1'b0; g_stb = 1'b0;
    tick();
    frd("rd40_new", 16'h0040, 16'h1357);

    // Back-to-back zero-wait writes then reads.
    f_stb = 1'b1; f_wre = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_adr = 16'h0060 + 16'(i); f_dto = 16'hA0C0 + 16'(i);
      tick();
      chk("b2b_wr_ack", f_ack, 1);
    end
    f_wre = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_adr = 16'h0060 + 16'(i);
      tick();
      chk("b2b_rd_ack", f_ack, 1);
      chk("b2b_rd_dti", f_dti, 16'hA0C0 + 16'(i));
    end
    f_stb = 1'b0;
    tick();
    chk("b2b_end", f_ack, 0);

    // dut1: reset during BUSY aborts the write.
    rst1 = 1'b0;
    tick();
    bg_adr = 16'h0050; bg_dto = 16'h0F0F; bg_wre = 1'b1; bg_stb = 1'b1;
    tick(); chk("d1_pre_ack", bg_ack, 1);
    bg_stb = 1'b0; bg_wre = 1'b0;
    bf_adr = 16'h0050; bf_wre = 1'b0; bf_stb = 1'b1;
    tick(); chk("d1_rd0", bf_ack, 0);
    tick(); chk("d1_rd1", bf_ack, 0);
    tick(); chk("d1_rd2", bf_ack, 1);
    chk("d1_rd_dti", bf_dti, 16'h0F0F);
    bf_wre = 1'b1; bf_dto = 16'h1111;
    tick(); chk("d1_wr_busy", bf_ack, 0);
    rst1 = 1'b1;
    tick();
    chk("d1_rst_ack", bf_ack, 0);
    chk("d1_rst_dti", bf_dti, 16'h0000);
    rst1 = 1'b0; bf_stb = 1'b0; bf_wre = 1'b0;
    tick(); chk("d1_post0", bf_ack, 0);
    tick(); chk("d1_post1", bf_ack, 0);
    bg_adr = 16'h0050; bg_wre = 1'b0; bg_stb = 1'b1;
    tick();
    chk("d1_chk_ack", bg_ack, 1);
    chk("d1_chk_dat", bg_dti, 16'h0F0F);
    bg_stb = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
